pmul_reg_bank: RTL

PMUL_REG_BANK -- requirements
Module: pmul_reg_bank

---
 rtl/pmul_reg_pkg.sv | 40 ++++
 rtl/pmul_operand_ram.sv | 54 +++++
 rtl/pmul_reg_bank.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/pmul_reg_pkg.sv
// Shared register map, status bit positions and control FSM encoding
// for the point-multiplier host register bank.
package pmul_reg_pkg;

  localparam logic [3:0] SEL_CTRL     = 4'd0;
  localparam logic [3:0] SEL_STATUS   = 4'd1;
  localparam logic [3:0] SEL_CYCLES   = 4'd2;
  localparam logic [3:0] SEL_TIMEOUT  = 4'd3;
  localparam logic [3:0] SEL_IN_BASE  = 4'd4;
  localparam logic [3:0] SEL_OUT_BASE = 4'd8;

  localparam int unsigned STAT_BUSY    = 0;
  localparam int unsigned STAT_DONE    = 1;
  localparam int unsigned STAT_ERR     = 2;
  localparam int unsigned STAT_TIMEOUT = 3;

  localparam int unsigned CTRL_GO  = 0;
  localparam int unsigned CTRL_CLR = 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_BUSY  = 2'd2
  } state_e;

  function automatic int unsigned addr_w(input int unsigned words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

  function automatic logic [7:0] byte_of32(input logic [31:0] v, input int unsigned idx);
    case (idx)
      0:       return v[7:0];
      1:       return v[15:8];
      2:       return v[23:16];
      3:       return v[31:24];
      default: return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/pmul_operand_ram.sv
// One operand of pOPERAND_WIDTH bits: host byte write/read, core word read
// (combinational) and core word write, little-endian byte ordering.
module pmul_operand_ram #(
  parameter int unsigned pOPERAND_WIDTH = 256,
  parameter int unsigned pWORD_WIDTH    = 32,
  parameter int unsigned pADDR_W        = 3,
  parameter int unsigned pBYTE_IDX_W    = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   byte_we,
  input  logic [pBYTE_IDX_W-1:0] byte_idx,
  input  logic [7:0]             byte_wdata,
  output logic [7:0]             byte_rdata,
  input  logic [pADDR_W-1:0]     word_raddr,
  output logic [pWORD_WIDTH-1:0] word_rdata,
  input  logic                   word_we,
  input  logic [pADDR_W-1:0]     word_waddr,
  input  logic [pWORD_WIDTH-1:0] word_wdata
);

  localparam int unsigned NBYTES = pOPERAND_WIDTH / 8;
  localparam int unsigned WBYTES = pWORD_WIDTH / 8;

  logic [NBYTES-1:0][7:0] mem_q, mem_d;

  // Indices past the operand never match any byte, so they read 0 and drop writes.
  always_comb begin
    mem_d = mem_q;
    for (int unsigned b = 0; b < NBYTES; b++) begin
      if (word_we && (32'(word_waddr) == b / WBYTES))
        mem_d[b] = word_wdata[(b % WBYTES)*8 +: 8];
      if (byte_we && (32'(byte_idx) == b))
        mem_d[b] = byte_wdata;
    end
  end

  always_comb begin
    byte_rdata = '0;
    word_rdata = '0;
    for (int unsigned b = 0; b < NBYTES; b++) begin
      if (32'(byte_idx) == b)
        byte_rdata = mem_q[b];
      if (32'(word_raddr) == b / WBYTES)
        word_rdata[(b % WBYTES)*8 +: 8] = mem_q[b];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) mem_q <= '0;
    else     mem_q <= mem_d;
  end

endmodule

// File: rtl/pmul_reg_bank.sv
// Host register bank and start/done/timeout sequencer around a point
// multiplier core: operand/result storage, status flags and cycle counter.
module pmul_reg_bank
  import pmul_reg_pkg::*;
#(
  parameter int unsigned pOPERAND_WIDTH = 256,
  parameter int unsigned pWORD_WIDTH    = 32,
  parameter int unsigned pNUM_IN        = 3,
  parameter int unsigned pNUM_OUT       = 2,
  parameter int unsigned pBYTECNT_SIZE  = 8
) (
  input  logic                                          crypto_clk,
  input  logic                                          reset_i,
  input  logic [3:0]                                    reg_sel,
  input  logic [pBYTECNT_SIZE-1:0]                      reg_bytecnt,
  input  logic                                          reg_write,
  input  logic                                          reg_read,
  input  logic [7:0]                                    write_data,
  output logic [7:0]                                    read_data,
  input  logic [1:0]                                    core_rd_sel,
  input  logic [addr_w(pOPERAND_WIDTH/pWORD_WIDTH)-1:0] core_rd_addr,
  output logic [pWORD_WIDTH-1:0]                        core_rd_word,
  input  logic                                          core_wr_en,
  input  logic [1:0]                                    core_wr_sel,
  input  logic [addr_w(pOPERAND_WIDTH/pWORD_WIDTH)-1:0] core_wr_addr,
  input  logic [pWORD_WIDTH-1:0]                        core_wr_word,
  output logic                                          O_start,
  input  logic                                          I_done,
  output logic                                          O_abort,
  output logic                                          O_busy
);

  localparam int unsigned AW = addr_w(pOPERAND_WIDTH / pWORD_WIDTH);

  state_e                 state_q, state_d;
  logic                   i_done_q;
  logic                   done_q, done_d, err_q, err_d, tmo_flag_q, tmo_flag_d;
  logic [31:0]            cycles_q, cycles_d, tmo_reg_q, tmo_reg_d;
  logic [7:0]             rdata_q, rdata_d;
  logic [pWORD_WIDTH-1:0] crd_q, crd_d;

  logic [pNUM_IN-1:0]     in_we;
  logic [7:0]             in_byte [pNUM_IN];
  logic [pWORD_WIDTH-1:0] in_word [pNUM_IN];
  logic [pNUM_OUT-1:0]    out_wwe;
  logic [7:0]             out_byte [pNUM_OUT];
  logic [pWORD_WIDTH-1:0] out_word [pNUM_OUT];

  logic idle, done_rise, tmo_match, ctrl_wr, go, clr, in_wr, tmo_wr;
  logic [7:0] rd_byte;
  logic unused_ok;

  assign idle      = (state_q == S_IDLE);
  assign done_rise = I_done & ~i_done_q;
  assign tmo_match = (tmo_reg_q != '0) && (cycles_q == tmo_reg_q);
  assign ctrl_wr   = reg_write && (reg_sel == SEL_CTRL) && (reg_bytecnt == '0);
  assign go        = ctrl_wr && write_data[CTRL_GO];
  assign clr       = ctrl_wr && write_data[CTRL_CLR];
  assign tmo_wr    = reg_write && (reg_sel == SEL_TIMEOUT);

  always_comb begin
    in_wr = 1'b0;
    for (int unsigned i = 0; i < pNUM_IN; i++) begin
      in_we[i] = 1'b0;
      if (reg_write && (reg_sel == SEL_IN_BASE + 4'(i))) begin
        in_wr    = 1'b1;
        in_we[i] = idle;
      end
    end
    for (int unsigned j = 0; j < pNUM_OUT; j++)
      out_wwe[j] = (state_q == S_BUSY) && core_wr_en && (32'(core_wr_sel) == j);
  end

  always_ff @(posedge crypto_clk or posedge reset_i) begin
    if (reset_i) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (go) state_d = S_START;
      S_START: state_d = S_BUSY;
      S_BUSY:  if (done_rise || tmo_match) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    O_start = (state_q == S_START);
    O_busy  = (state_q != S_IDLE);
    O_abort = (state_q == S_BUSY) && tmo_match && !done_rise;
  end

  // Clear is applied before go, so clear+go from IDLE starts with clean flags
  // while clear+go during an operation still reports the rejected go as err.
  always_comb begin
    done_d     = done_q;
    err_d      = err_q;
    tmo_flag_d = tmo_flag_q;
    cycles_d   = cycles_q;
    tmo_reg_d  = tmo_reg_q;
    if (clr) begin
      done_d     = 1'b0;
      err_d      = 1'b0;
      tmo_flag_d = 1'b0;
    end
    if (go && idle) begin
      done_d     = 1'b0;
      tmo_flag_d = 1'b0;
      cycles_d   = '0;
    end
    if (!idle && (go || in_wr || tmo_wr)) err_d = 1'b1;
    if (state_q == S_BUSY) begin
      if (done_rise)             done_d     = 1'b1;
      else if (tmo_match)        tmo_flag_d = 1'b1;
      else if (cycles_q != '1)   cycles_d   = cycles_q + 32'd1;
    end
    if (tmo_wr && idle) begin
      for (int unsigned b = 0; b < 4; b++)
        if (32'(reg_bytecnt) == b) tmo_reg_d[b*8 +: 8] = write_data;
    end
  end

  always_comb begin
    rd_byte = '0;
    if (reg_sel == SEL_STATUS) begin
      if (reg_bytecnt == '0) begin
        rd_byte[STAT_BUSY]    = !idle;
        rd_byte[STAT_DONE]    = done_q;
        rd_byte[STAT_ERR]     = err_q;
        rd_byte[STAT_TIMEOUT] = tmo_flag_q;
      end
    end else if (reg_sel == SEL_CYCLES) begin
      rd_byte = byte_of32(cycles_q, 32'(reg_bytecnt));
    end else if (reg_sel == SEL_TIMEOUT) begin
      rd_byte = byte_of32(tmo_reg_q, 32'(reg_bytecnt));
    end
    for (int unsigned i = 0; i < pNUM_IN; i++)
      if (reg_sel == SEL_IN_BASE + 4'(i)) rd_byte = in_byte[i];
    for (int unsigned j = 0; j < pNUM_OUT; j++)
      if (reg_sel == SEL_OUT_BASE + 4'(j)) rd_byte = out_byte[j];
    rdata_d = reg_read ? rd_byte : '0;
  end

  always_comb begin
    crd_d = '0;
    for (int unsigned i = 0; i < pNUM_IN; i++)
      if (32'(core_rd_sel) == i) crd_d = in_word[i];
  end

  always_ff @(posedge crypto_clk or posedge reset_i) begin
    if (reset_i) begin
      i_done_q   <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      tmo_flag_q <= 1'b0;
      cycles_q   <= '0;
      tmo_reg_q  <= '0;
      rdata_q    <= '0;
      crd_q      <= '0;
    end else begin
      i_done_q   <= I_done;
      done_q     <= done_d;
      err_q      <= err_d;
      tmo_flag_q <= tmo_flag_d;
      cycles_q   <= cycles_d;
      tmo_reg_q  <= tmo_reg_d;
      rdata_q    <= rdata_d;
      crd_q      <= crd_d;
    end
  end

  assign read_data    = rdata_q;
  assign core_rd_word = crd_q;

  for (genvar gi = 0; gi < pNUM_IN; gi++) begin : g_in
    pmul_operand_ram #(
      .pOPERAND_WIDTH (pOPERAND_WIDTH),
      .pWORD_WIDTH    (pWORD_WIDTH),
      .pADDR_W        (AW),
      .pBYTE_IDX_W    (pBYTECNT_SIZE)
    ) u_ram (
      .clk        (crypto_clk),
      .rst        (reset_i),
      .byte_we    (in_we[gi]),
      .byte_idx   (reg_bytecnt),
      .byte_wdata (write_data),
      .byte_rdata (in_byte[gi]),
      .word_raddr (core_rd_addr),
      .word_rdata (in_word[gi]),
      .word_we    (1'b0),
      .word_waddr ('0),
      .word_wdata ('0)
    );
  end

  for (genvar gj = 0; gj < pNUM_OUT; gj++) begin : g_out
    pmul_operand_ram #(
      .pOPERAND_WIDTH (pOPERAND_WIDTH),
      .pWORD_WIDTH    (pWORD_WIDTH),
      .pADDR_W        (AW),
      .pBYTE_IDX_W    (pBYTECNT_SIZE)
    ) u_ram (
      .clk        (crypto_clk),
      .rst        (reset_i),
      .byte_we    (1'b0),
      .byte_idx   (reg_bytecnt),
      .byte_wdata (8'h00),
      .byte_rdata (out_byte[gj]),
      .word_raddr ('0),
      .word_rdata (out_word[gj]),
      .word_we    (out_wwe[gj]),
      .word_waddr (core_wr_addr),
      .word_wdata (core_wr_word)
    );
  end

  // Results are host-read bytewise only; their word read port has no consumer.
  always_comb begin
    unused_ok = 1'b0;
    for (int unsigned j = 0; j < pNUM_OUT; j++) unused_ok = unused_ok ^ (^out_word[j]);
  end

endmodule
